cache_nway: RTL and testbench

Parametrised, fully synchronous N-way set-associative cache between a CPU-side port (instruction or data) and the memory arbiter. It replaces the event-driven two-way cache with a single-clock FSM, configurable way count and line size, write masking and round-robin replacement. The write-back/write-allocate policy is selectable at compile time.

---
 rtl/cache_nway_if.sv | 36 +++
 rtl/cache_nway.sv | 236 +++++++++++++++++++++++
 tb/tb_cache_nway.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_if.sv
// CPU-side and memory-side signal bundle for cache_nway.
// slave is the cache's view; master is the requester/memory side.
interface cache_nway_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] c_raddr;
  logic [ADDR_W-1:0] c_waddr;
  logic              c_re;
  logic              c_we;
  logic [1:0]        c_wlen;
  logic [31:0]       c_din;
  logic [31:0]       c_dout;
  logic              c_rack;
  logic              c_wack;

  logic [ADDR_W-1:0] m_raddr;
  logic [ADDR_W-1:0] m_waddr;
  logic              m_re;
  logic              m_we;
  logic [1:0]        m_rlen;
  logic [1:0]        m_wlen;
  logic [31:0]       m_dout;
  logic [31:0]       m_din;
  logic              m_rack;
  logic              m_wack;

  modport slave (
    input  c_raddr, c_waddr, c_re, c_we, c_wlen, c_din, m_din, m_rack, m_wack,
    output c_dout, c_rack, c_wack, m_raddr, m_waddr, m_re, m_we, m_rlen, m_wlen, m_dout
  );

  modport master (
    output c_raddr, c_waddr, c_re, c_we, c_wlen, c_din, m_din, m_rack, m_wack,
    input  c_dout, c_rack, c_wack, m_raddr, m_waddr, m_re, m_we, m_rlen, m_wlen, m_dout
  );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative cache with round-robin replacement and byte-masked writes.
// CACHE_WRITE_BACK_EN selects write-back/write-allocate; otherwise write-through, no allocate.
module cache_nway #(
  parameter int unsigned ID     = 0,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_B = 3,
  parameter int unsigned IDX_B  = 5,
  parameter int unsigned WAYS   = 2
) (
  input logic         clk,
  input logic         rst,
  cache_nway_if.slave bus
);
`ifdef CACHE_WRITE_BACK_EN
  localparam bit WriteBack = 1'b1;
`else
  localparam bit WriteBack = 1'b0;
`endif

  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_LO = IDX_B + WORD_B + 2;
  localparam int unsigned TAG_W  = ADDR_W - TAG_LO;
  localparam int unsigned ENT_W  = WAY_W + IDX_B;
  localparam int unsigned DAT_W  = ENT_W + WORD_B;

  typedef enum logic [2:0] {
    StIdle, StLookup, StFlush, StFlushWait, StFill, StFillWait, StWtWait, StResp
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              is_wr_q;
  logic [1:0]        wlen_q;
  logic [31:0]       wdata_q;
  logic              gap_q;
  logic [WAY_W-1:0]  vic_q;
  logic              use_ptr_q;
  logic [WORD_B-1:0] cnt_q;

  logic [(2**ENT_W)-1:0]               valid_q;
  logic [(2**ENT_W)-1:0]               dirty_q;
  logic [TAG_W-1:0]                    tag_q  [2**ENT_W];
  logic [31:0]                         data_q [2**DAT_W];
  logic [(2**IDX_B)-1:0][WAY_W-1:0]    vptr_q;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_B-1:0]  a_idx;
  logic [WORD_B-1:0] a_word;
  assign a_tag  = addr_q[ADDR_W-1:TAG_LO];
  assign a_idx  = addr_q[TAG_LO-1:WORD_B+2];
  assign a_word = addr_q[WORD_B+1:2];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] din, logic [1:0] len,
                                        logic [1:0] lane);
    logic [3:0]  be;
    logic [31:0] sh;
    logic [31:0] res;
    case (len)
      2'b00:   begin be = 4'b0001 << lane;                  sh = {4{din[7:0]}};  end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;      sh = {2{din[15:0]}}; end
      default: begin be = 4'b1111;                          sh = din;            end
    endcase
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = sh[8*b +: 8];
    end
    return res;
  endfunction

  logic             hit;
  logic             inv_found;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] vic_way;
  logic [31:0]      hit_word;
  logic [31:0]      merged;
  logic [TAG_W-1:0] vic_tag;
  logic [31:0]      flush_word;

  // Lowest-index invalid way wins over the round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[{WAY_W'(w), a_idx}] && tag_q[{WAY_W'(w), a_idx}] == a_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[{WAY_W'(w), a_idx}] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vic_way = inv_found ? inv_way : vptr_q[a_idx];
  end

  assign hit_word   = data_q[{hit_way, a_idx, a_word}];
  assign merged     = merge(hit_word, wdata_q, wlen_q, addr_q[1:0]);
  assign vic_tag    = tag_q[{vic_q, a_idx}];
  assign flush_word = data_q[{vic_q, a_idx, cnt_q}];

  assign bus.m_rlen = 2'b11;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      vptr_q      <= '0;
      gap_q       <= 1'b0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      wlen_q      <= 2'b00;
      wdata_q     <= '0;
      vic_q       <= '0;
      use_ptr_q   <= 1'b0;
      cnt_q       <= '0;
      bus.c_dout  <= '0;
      bus.c_rack  <= 1'b0;
      bus.c_wack  <= 1'b0;
      bus.m_raddr <= '0;
      bus.m_waddr <= '0;
      bus.m_re    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_wlen  <= 2'b00;
      bus.m_dout  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The cycle after a response is skipped so the requester can drop its request.
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (bus.c_we) begin
            addr_q  <= bus.c_waddr;
            is_wr_q <= 1'b1;
            wlen_q  <= bus.c_wlen;
            wdata_q <= bus.c_din;
            state_q <= StLookup;
          end else if (bus.c_re) begin
            addr_q  <= bus.c_raddr;
            is_wr_q <= 1'b0;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (is_wr_q && !WriteBack) begin
            if (hit) data_q[{hit_way, a_idx, a_word}] <= merged;
            bus.m_we    <= 1'b1;
            bus.m_waddr <= addr_q;
            bus.m_wlen  <= wlen_q;
            bus.m_dout  <= wdata_q;
            state_q     <= StWtWait;
          end else if (!hit) begin
            vic_q     <= vic_way;
            use_ptr_q <= !inv_found;
            cnt_q     <= '0;
            state_q   <= dirty_q[{vic_way, a_idx}] ? StFlush : StFill;
          end else if (is_wr_q) begin
            data_q[{hit_way, a_idx, a_word}] <= merged;
            dirty_q[{hit_way, a_idx}]        <= 1'b1;
            bus.c_wack                       <= 1'b1;
            state_q                          <= StResp;
          end else begin
            bus.c_dout <= hit_word;
            bus.c_rack <= 1'b1;
            state_q    <= StResp;
          end
        end
        StFlush: begin
          bus.m_we    <= 1'b1;
          bus.m_waddr <= {vic_tag, a_idx, cnt_q, 2'b00};
          bus.m_wlen  <= 2'b11;
          bus.m_dout  <= flush_word;
          state_q     <= StFlushWait;
        end
        StFlushWait: begin
          if (bus.m_wack) begin
            bus.m_we <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
            state_q  <= (cnt_q == '1) ? StFill : StFlush;
          end
        end
        StFill: begin
          bus.m_re    <= 1'b1;
          bus.m_raddr <= {a_tag, a_idx, cnt_q, 2'b00};
          state_q     <= StFillWait;
        end
        StFillWait: begin
          if (bus.m_rack) begin
            bus.m_re                       <= 1'b0;
            data_q[{vic_q, a_idx, cnt_q}]  <= bus.m_din;
            cnt_q                          <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              valid_q[{vic_q, a_idx}] <= 1'b1;
              dirty_q[{vic_q, a_idx}] <= 1'b0;
              tag_q[{vic_q, a_idx}]   <= a_tag;
              if (use_ptr_q) begin
                vptr_q[a_idx] <= (vptr_q[a_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                      : vptr_q[a_idx] + 1'b1;
              end
              state_q <= StLookup;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StWtWait: begin
          if (bus.m_wack) begin
            bus.m_we   <= 1'b0;
            bus.c_wack <= 1'b1;
            state_q    <= StResp;
          end
        end
        StResp: begin
          bus.c_rack <= 1'b0;
          bus.c_wack <= 1'b0;
          gap_q      <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && bus.m_rack && state_q != StFillWait) begin
      $display("cache_nway[%0d] error: unexpected m_rack ignored", ID);
    end
    if (!rst && bus.m_wack && !(state_q inside {StFlushWait, StWtWait})) begin
      $display("cache_nway[%0d] error: unexpected m_wack ignored", ID);
    end
  end
`endif
endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway: expectations are queued at issue, monitors pop on acks.
`timescale 1ns/1ps
module tb_cache_nway;
  localparam int unsigned MemLat = 2;
  localparam int unsigned Budget = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_nway_if #(.ADDR_W(32)) bus ();

  cache_nway #(
    .ID(0), .ADDR_W(32), .WORD_B(3), .IDX_B(5), .WAYS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic is_wr; logic [31:0] data; } cpu_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] len; } mwr_exp_t;

  cpu_exp_t    exp_cpu[$];
  logic [31:0] exp_mrd[$];
  mwr_exp_t    exp_mwr[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endfunction

  function automatic void fail(string name, logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%08h, nothing was expected", name, act);
  endfunction

  // CPU response monitor
  initial begin : cpu_mon
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.c_rack || bus.c_wack) begin
        if (exp_cpu.size() == 0) begin
          fail("cpu ack", {30'b0, bus.c_wack, bus.c_rack});
        end else begin
          e = exp_cpu.pop_front();
          chk("cpu ack kind", {30'b0, bus.c_wack, bus.c_rack}, e.is_wr ? 32'd2 : 32'd1);
          if (!e.is_wr) chk("c_dout", bus.c_dout, e.data);
        end
      end
    end
  end

  // Memory read responder: returns addr + 0xA0 after MemLat cycles
  initial begin : mem_rd
    int wait_n;
    wait_n = 0;
    bus.m_rack = 1'b0;
    bus.m_din  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_rack) begin
        bus.m_rack = 1'b0;
      end else if (bus.m_re) begin
        wait_n++;
        if (wait_n >= MemLat) begin
          wait_n = 0;
          if (exp_mrd.size() == 0) fail("m_raddr", bus.m_raddr);
          else chk("m_raddr", bus.m_raddr, exp_mrd.pop_front());
          chk("m_rlen", {30'b0, bus.m_rlen}, 32'd3);
          bus.m_din  = bus.m_raddr + 32'hA0;
          bus.m_rack = 1'b1;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Memory write responder
  initial begin : mem_wr
    int       wait_n;
    mwr_exp_t e;
    wait_n = 0;
    bus.m_wack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_wack) begin
        bus.m_wack = 1'b0;
      end else if (bus.m_we) begin
        wait_n++;
        if (wait_n >= MemLat) begin
          wait_n = 0;
          if (exp_mwr.size() == 0) begin
            fail("m_waddr", bus.m_waddr);
          end else begin
            e = exp_mwr.pop_front();
            chk("m_waddr", bus.m_waddr, e.addr);
            chk("m_dout", bus.m_dout, e.data);
            chk("m_wlen", {30'b0, bus.m_wlen}, {30'b0, e.len});
          end
          bus.m_wack = 1'b1;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  task automatic push_fill(input logic [31:0] base);
    for (int w = 0; w < 8; w++) exp_mrd.push_back(base + 32'(4 * w));
  endtask

  task automatic wait_ack(input bit is_wr, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_wr ? bus.c_wack : bus.c_rack) && lat < Budget);
    if (!(is_wr ? bus.c_wack : bus.c_rack)) fail(is_wr ? "c_wack timeout" : "c_rack timeout", 0);
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] d, output int lat);
    exp_cpu.push_back('{is_wr: 1'b0, data: d});
    repeat (2) @(negedge clk);
    bus.c_raddr = a;
    bus.c_re    = 1'b1;
    wait_ack(1'b0, lat);
    bus.c_re = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d,
                           output int lat);
    exp_cpu.push_back('{is_wr: 1'b1, data: 32'h0});
    repeat (2) @(negedge clk);
    bus.c_waddr = a;
    bus.c_wlen  = len;
    bus.c_din   = d;
    bus.c_we    = 1'b1;
    wait_ack(1'b1, lat);
    bus.c_we = 1'b0;
  endtask

  task automatic chk_drained(string name);
    chk({name, " mrd left"}, exp_mrd.size(), 0);
    chk({name, " mwr left"}, exp_mwr.size(), 0);
    chk({name, " cpu left"}, exp_cpu.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int guard;
    rst = 1'b1;
    bus.c_raddr = '0; bus.c_waddr = '0; bus.c_re = 1'b0; bus.c_we = 1'b0;
    bus.c_wlen  = 2'b11; bus.c_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset c_rack", {31'b0, bus.c_rack}, 32'd0);
    chk("reset c_wack", {31'b0, bus.c_wack}, 32'd0);
    chk("reset m_re",   {31'b0, bus.m_re},   32'd0);
    chk("reset m_we",   {31'b0, bus.m_we},   32'd0);

    // Cold miss then hit in the same line
    push_fill(32'h100);
    cpu_read(32'h100, 32'h1A0, lat);
    chk_drained("fill 0x100");
    cpu_read(32'h104, 32'h1A4, lat);
    chk("hit latency 0x104", lat, 2);
    chk_drained("hit 0x104");

`ifdef CACHE_WRITE_BACK_EN
    cpu_write(32'h102, 2'b00, 32'h5A, lat);
    chk("write hit latency", lat, 2);
    cpu_read(32'h100, 32'h005A01A0, lat);
    chk_drained("byte write 0x102");

    // Conflict: second way fills, third line evicts dirty way 0
    push_fill(32'h1100);
    cpu_read(32'h1100, 32'h11A0, lat);
    for (int w = 0; w < 8; w++) begin
      exp_mwr.push_back('{addr: 32'h100 + 32'(4 * w),
                          data: (w == 0) ? 32'h005A01A0 : 32'h1A0 + 32'(4 * w),
                          len: 2'b11});
    end
    push_fill(32'h2100);
    cpu_read(32'h2100, 32'h21A0, lat);
    chk_drained("evict dirty 0x100");

    // Simultaneous: write miss allocates 0x200, then read 0x100 evicts way 1 (clean)
    push_fill(32'h200);
    push_fill(32'h100);
    exp_cpu.push_back('{is_wr: 1'b1, data: 32'h0});
    exp_cpu.push_back('{is_wr: 1'b0, data: 32'h1A0});
`else
    exp_mwr.push_back('{addr: 32'h102, data: 32'h5A, len: 2'b00});
    cpu_write(32'h102, 2'b00, 32'h5A, lat);
    cpu_read(32'h100, 32'h005A01A0, lat);
    chk("hit latency 0x100", lat, 2);
    chk_drained("wt byte write 0x102");

    exp_mwr.push_back('{addr: 32'h300, data: 32'hDEADBEEF, len: 2'b11});
    cpu_write(32'h300, 2'b11, 32'hDEADBEEF, lat);
    chk_drained("wt miss 0x300");
    push_fill(32'h300);
    cpu_read(32'h300, 32'h3A0, lat);
    chk_drained("no allocate 0x300");

    exp_mwr.push_back('{addr: 32'h200, data: 32'h12345678, len: 2'b11});
    exp_cpu.push_back('{is_wr: 1'b1, data: 32'h0});
    exp_cpu.push_back('{is_wr: 1'b0, data: 32'h005A01A0});
`endif
    repeat (2) @(negedge clk);
    bus.c_waddr = 32'h200; bus.c_wlen = 2'b11; bus.c_din = 32'h12345678; bus.c_we = 1'b1;
    bus.c_raddr = 32'h100; bus.c_re = 1'b1;
    wait_ack(1'b1, lat);
    bus.c_we = 1'b0;
    wait_ack(1'b0, lat);
    bus.c_re = 1'b0;
    chk_drained("simultaneous");

`ifdef CACHE_WRITE_BACK_EN
    cpu_read(32'h200, 32'h12345678, lat);
    chk("hit latency 0x200", lat, 2);
    chk_drained("allocated 0x200");
`endif

    // Reset while a fill is outstanding
    repeat (2) @(negedge clk);
    bus.c_raddr = 32'h400;
    bus.c_re    = 1'b1;
    guard = 0;
    while (!bus.m_re && guard < Budget) begin
      @(negedge clk);
      guard++;
    end
    chk("m_re before reset", {31'b0, bus.m_re}, 32'd1);
    rst      = 1'b1;
    bus.c_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("m_re after reset", {31'b0, bus.m_re}, 32'd0);
    chk("c_rack after reset", {31'b0, bus.c_rack}, 32'd0);
    push_fill(32'h400);
    cpu_read(32'h400, 32'h4A0, lat);
    chk_drained("refill 0x400");
    // Dirty lines are discarded: no write-back, plain refill
    push_fill(32'h200);
    cpu_read(32'h200, 32'h2A0, lat);
    chk_drained("refill 0x200");

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
